// File: rtl/demux4_buf.sv
// rtl/demux4_buf.sv - 1-to-4 stream demux with one-entry holding register per channel; optional per-channel delivery counters under DEMUX4_BUF_CNT_EN
module demux4_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data_a,
  output logic [WIDTH-1:0] out_data_b,
  output logic [WIDTH-1:0] out_data_c,
  output logic [WIDTH-1:0] out_data_d,
`ifdef DEMUX4_BUF_CNT_EN
  input  logic             cnt_clr,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b,
  output logic [15:0]      cnt_c,
  output logic [15:0]      cnt_d,
`endif
  output logic             busy
);

  logic [3:0][WIDTH-1:0] data_q;
  logic [3:0]            valid_q;
  logic [3:0]            load;
  logic [3:0]            drain;
  logic                  accept;

  // A channel can take a word if it is empty or is being drained this edge
  always_comb begin
    in_ready = rst_n && (!valid_q[in_sel] || out_ready[in_sel]);
    accept   = in_valid && in_ready;
    load     = 4'b0000;
    if (accept) begin
      load[in_sel] = 1'b1;
    end
    drain    = valid_q & out_ready;
  end

  // Holding registers: load replaces contents, drain clears valid unless reloaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          data_q[i] <= in_data;
        end
        valid_q[i] <= load[i] || (valid_q[i] && !out_ready[i]);
      end
    end
  end

  assign out_valid  = valid_q;
  assign busy       = |valid_q;
  assign out_data_a = data_q[0];
  assign out_data_b = data_q[1];
  assign out_data_c = data_q[2];
  assign out_data_d = data_q[3];

`ifdef DEMUX4_BUF_CNT_EN
  logic [3:0][15:0] cnt_q;

  // Per-channel delivered-word counters; clear wins over a same-cycle delivery
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_clr) begin
          cnt_q[i] <= 16'h0000;
        end else if (drain[i]) begin
          cnt_q[i] <= cnt_q[i] + 16'h0001;
        end
      end
    end
  end

  assign cnt_a = cnt_q[0];
  assign cnt_b = cnt_q[1];
  assign cnt_c = cnt_q[2];
  assign cnt_d = cnt_q[3];
`else
  logic unused_drain;
  assign unused_drain = |drain;
`endif

endmodule
